// File: rtl/divc_pkg.sv
// ============================================================================
//  Module      : divc_pkg
//  Description : Shared constants and types for the sequential
//                divide-by-constant engine (divc_seq_ctrl).
//                  DIVC_W       dividend / quotient width
//                  DIVC_CHUNK   dividend bits consumed per step
//                  DIVC_DIVISOR constant divisor
//                  DIVC_RW      remainder width (clog2 of divisor)
//                  DIVC_NSTEP   number of steps per division
//                Optional feature macro: DIVC_REM_OUT_EN (see divc_seq_ctrl).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package divc_pkg;

    localparam int DIVC_W       = 36;
    localparam int DIVC_CHUNK   = 4;
    localparam int DIVC_DIVISOR = 113;
    localparam int DIVC_RW      = 7;
    localparam int DIVC_NSTEP   = DIVC_W / DIVC_CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divc_state_t;

    // Width of a counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int divc_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divc_seq_ctrl_if.sv
// ============================================================================
//  Module      : divc_seq_ctrl_if
//  Description : Operand / result handshake bundle for divc_seq_ctrl.
//                  in_valid/in_ready/in_dividend     operand channel
//                  out_valid/out_ready/out_quotient  result channel
//                  busy                              engine not idle
//                  out_remainder                     final remainder, only
//                                                    when DIVC_REM_OUT_EN is
//                                                    defined
//                master : operand source / result consumer side
//                slave  : the division engine
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface divc_seq_ctrl_if #(
    parameter int W = divc_pkg::DIVC_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic         busy;
`ifdef DIVC_REM_OUT_EN
    logic [divc_pkg::DIVC_RW-1:0] out_remainder;
`endif

`ifdef DIVC_REM_OUT_EN
    modport master (
        output in_valid,
        output in_dividend,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_quotient,
        input  busy,
        input  out_remainder
    );

    modport slave (
        input  in_valid,
        input  in_dividend,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_quotient,
        output busy,
        output out_remainder
    );
`else
    modport master (
        output in_valid,
        output in_dividend,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_quotient,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_dividend,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_quotient,
        output busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/divc_step.sv
// ============================================================================
//  Module      : divc_step
//  Description : Combinational long-division step by a constant divisor.
//                Concatenates the running remainder with the next dividend
//                chunk and produces one quotient digit plus the new remainder.
//                  rem    [RW-1:0]     running remainder (< DIVISOR)
//                  chunk  [CHUNK-1:0]  next dividend bits, MSB-first
//                  digit  [CHUNK-1:0]  quotient digit for this step
//                  rem_nx [RW-1:0]     remainder after this step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module divc_step
    import divc_pkg::*;
#(
    parameter int CHUNK   = DIVC_CHUNK,
    parameter int DIVISOR = DIVC_DIVISOR,
    parameter int RW      = DIVC_RW
) (
    input  wire logic [RW-1:0]    rem,
    input  wire logic [CHUNK-1:0] chunk,
    output logic      [CHUNK-1:0] digit,
    output logic      [RW-1:0]    rem_nx
);

    localparam int            c_tw  = RW + CHUNK;
    localparam logic [c_tw-1:0] c_div = c_tw'(DIVISOR);

    logic [c_tw-1:0] w_t;

    assign w_t = {rem, chunk};

    // rem < DIVISOR, so w_t < DIVISOR * 2**CHUNK: the digit always fits in
    // CHUNK bits and the remainder in RW bits, making both truncations exact.
    assign digit  = CHUNK'(w_t / c_div);
    assign rem_nx = RW'(w_t % c_div);

endmodule

`default_nettype wire

// File: rtl/divc_seq_ctrl.sv
// ============================================================================
//  Module      : divc_seq_ctrl
//  Description : Sequential divide-by-constant engine. Streams a W-bit
//                unsigned dividend MSB-first, CHUNK bits per cycle, through
//                divc_step and assembles the quotient. One result every
//                W/CHUNK + 2 cycles at best.
//                  clk  : clock, all state on rising edge
//                  rst  : synchronous active-high reset
//                  bus  : divc_seq_ctrl_if.slave (operand in, result out,
//                         busy, optional out_remainder)
//                Configuration macro: DIVC_REM_OUT_EN - drives
//                out_remainder with the final remainder register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module divc_seq_ctrl
    import divc_pkg::*;
#(
    parameter int W       = DIVC_W,
    parameter int CHUNK   = DIVC_CHUNK,
    parameter int DIVISOR = DIVC_DIVISOR,
    parameter int RW      = DIVC_RW
) (
    input  wire logic      clk,
    input  wire logic      rst,
    divc_seq_ctrl_if.slave bus
);

    localparam int            c_nstep = W / CHUNK;
    localparam int            c_cw    = divc_cnt_w(c_nstep);
    localparam logic [c_cw-1:0] c_last  = c_cw'(c_nstep - 1);

    divc_state_t       r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [W-1:0]      r_div;
    logic [W-1:0]      r_quot;
    logic [RW-1:0]     r_rem;
    logic [c_cw-1:0]   r_cnt;

    logic [CHUNK-1:0]  w_digit;
    logic [RW-1:0]     w_rem_nx;

    divc_step #(
        .CHUNK   (CHUNK),
        .DIVISOR (DIVISOR),
        .RW      (RW)
    ) u_step (
        .rem    (r_rem),
        .chunk  (r_div[W-1 -: CHUNK]),
        .digit  (w_digit),
        .rem_nx (w_rem_nx)
    );

    // Handshake outputs are registered alongside the state so they change
    // only on clock edges and never glitch combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_div       <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_div      <= bus.in_dividend;
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                    end
                end

                RUN: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= {r_quot[W-CHUNK-1:0], w_digit};
                    r_div  <= r_div << CHUNK;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    // Result registers are left untouched here so quotient
                    // and remainder stay stable until the consumer takes them.
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.busy         = r_busy;
    assign bus.out_quotient = r_quot;

`ifdef DIVC_REM_OUT_EN
    assign bus.out_remainder = r_rem;
`endif

endmodule

`default_nettype wire

// File: tb/tb_divc_seq_ctrl.sv
// ============================================================================
//  Module      : tb_divc_seq_ctrl
//  Description : Self-checking scoreboard bench for divc_seq_ctrl.
//                Expected results are pushed when an operand is accepted and
//                popped when the engine hands over a result.
//                Honours DIVC_REM_OUT_EN for remainder checking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_divc_seq_ctrl;
    import divc_pkg::*;

    localparam int W       = DIVC_W;
    localparam int RW      = DIVC_RW;
    localparam int N       = DIVC_NSTEP;
    localparam int DIV_REF = 113;
    localparam int NRAND   = 3000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divc_seq_ctrl_if #(.W(W)) bus ();

    divc_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0]  q;
        logic [RW-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d);
        exp_t        e;
        logic [63:0] dd;
        dd  = 64'(d);
        e.q = W'(dd / 64'(DIV_REF));
        e.r = RW'(dd % 64'(DIV_REF));
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_unexpected_result"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_q"}, 64'(bus.out_quotient), 64'(e.q));
`ifdef DIVC_REM_OUT_EN
            check_val({tag, "_rem"}, 64'(bus.out_remainder), 64'(e.r));
`endif
        end
    endtask

    task automatic wait_in_ready(input string tag);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check_val({tag, "_in_ready_timeout"}, 64'(bus.in_ready), 64'd1);
    endtask

    // One directed operation: accept, check latency, hold the result for
    // 'hold' cycles, then take it. With 'probe' set, in_valid stays high with
    // a different dividend the whole time to prove nothing else is captured.
    task automatic run_op(input string tag, input logic [W-1:0] d, input int hold, input bit probe);
        int           lat;
        logic [W-1:0] q_hold;
        wait_in_ready(tag);
        bus.in_valid    = 1'b1;
        bus.in_dividend = d;
        sb.push_back(model(d));
        @(negedge clk);
        bus.in_valid    = probe;
        bus.in_dividend = ~d;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(N));
        if (sb.size() != 0) q_hold = sb[0].q;
        else                q_hold = '0;
        for (int h = 0; h < hold; h++) begin
            check_val({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_val({tag, "_hold_q"}, 64'(bus.out_quotient), 64'(q_hold));
            check_val({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        compare_out(tag);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        check_val({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int           sent;
        int           recv;
        int           cyc;
        int           pulses;
        logic [W-1:0] d;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("reset_busy", 64'(bus.busy), 64'd0);
        check_val("reset_quotient", 64'(bus.out_quotient), 64'd0);
`ifdef DIVC_REM_OUT_EN
        check_val("reset_remainder", 64'(bus.out_remainder), 64'd0);
`endif

        run_op("d113", W'(113), 0, 1'b0);
        run_op("d0", W'(0), 0, 1'b0);
        run_op("d112", W'(112), 0, 1'b0);
        run_op("dmax", {W{1'b1}}, 0, 1'b0);
        run_op("d226_hold", W'(226), 5, 1'b1);
        check_val("d226_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of a run: no result may appear afterwards.
        wait_in_ready("rst_mid");
        bus.in_valid    = 1'b1;
        bus.in_dividend = W'(1000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_mid_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_mid_busy", 64'(bus.busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check_val("rst_mid_no_pulse", 64'(pulses), 64'd0);
        run_op("d1000_after_rst", W'(1000), 0, 1'b0);

        // Random traffic with random handshakes on both sides.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < NRAND && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            case ($urandom_range(15))
                0:       d = '0;
                1:       d = '1;
                2:       d = W'($urandom_range(300));
                default: d = W'({$urandom(), $urandom()});
            endcase
            bus.in_valid    = (sent < NRAND) && ($urandom_range(3) != 0);
            bus.in_dividend = d;
            bus.out_ready   = ($urandom_range(3) != 0);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(d));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                compare_out("rand");
                recv++;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_val("rand_received", 64'(recv), 64'(NRAND));
        check_val("rand_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
